// File: rtl/pelican_pkg.sv
// Shared constants, types and FSM encoding for the Pelican MAC host controller.
package pelican_pkg;

  localparam int W       = 128;  // block / key / IV / tag width
  localparam int MSG_NUM = 3;    // index of the last message block

  localparam int NUM_ENTRIES = MSG_NUM + 3;  // IV, key, MSG_NUM+1 message blocks
  localparam int ADDR_W      = 3;
  localparam int IDX_W       = 3;            // message index spans 0..MSG_NUM+1
  localparam int TMO_W       = 11;

  localparam logic [ADDR_W-1:0] ADDR_IV   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_KEY  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MSG0 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MSG_NUM + 2);

  // Last valid message index, and the "all blocks served" index.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_NUM);
  localparam logic [IDX_W-1:0] IDX_OVER = IDX_W'(MSG_NUM + 1);

  typedef logic [W-1:0] blk_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_e;

endpackage

// File: rtl/pelican_host_ctrl_if.sv
// Software-side buffer/run bus plus the MAC core handshake, bundled as one interface.
interface pelican_host_ctrl_if;
  import pelican_pkg::*;

  // software side
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  blk_t              wr_data;
  logic              start;
  blk_t              exp_tag;
  logic              busy;
  blk_t              tag;
  logic              tag_valid;
  logic              tag_match;
  logic              err;

  // MAC core side
  logic              core_rst;
  logic              core_load_iv;
  blk_t              core_din;
  logic              core_load_k;
  logic              core_load_m;
  blk_t              core_dout;
  logic              core_done;

  // Controller view.
  modport slave (
    input  wr_en, wr_addr, wr_data, start, exp_tag,
    output busy, tag, tag_valid, tag_match, err,
    output core_rst, core_load_iv, core_din,
    input  core_load_k, core_load_m, core_dout, core_done
  );

  // Software / core view.
  modport master (
    output wr_en, wr_addr, wr_data, start, exp_tag,
    input  busy, tag, tag_valid, tag_match, err,
    input  core_rst, core_load_iv, core_din,
    output core_load_k, core_load_m, core_dout, core_done
  );

endinterface

// File: rtl/pelican_blk_buf.sv
// Block buffer: IV, key and message blocks with one write port and three read taps.
module pelican_blk_buf
  import pelican_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  blk_t              wr_data_i,
  input  logic [IDX_W-1:0]  msg_idx_i,
  output blk_t              iv_o,
  output blk_t              key_o,
  output blk_t              msg_o
);

  blk_t              mem_q [NUM_ENTRIES];
  logic [IDX_W-1:0]  msg_sel;
  logic [ADDR_W-1:0] msg_addr;

  // Store a software write; addresses past the last message block are dropped.
  // NOTE: the buffer is plain data storage refilled by software, so it has no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_addr_i <= ADDR_LAST)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Once every block has been served the index sits one past the end; keep
  // presenting the last block in that case.
  assign msg_sel  = (msg_idx_i > IDX_LAST) ? IDX_LAST : msg_idx_i;
  assign msg_addr = ADDR_MSG0 + ADDR_W'(msg_sel);

  assign iv_o  = mem_q[ADDR_IV];
  assign key_o = mem_q[ADDR_KEY];
  assign msg_o = mem_q[msg_addr];

endmodule

// File: rtl/pelican_host_ctrl.sv
// Host controller for the Pelican MAC core: sequences reset, IV load, key and
// message service, then captures and compares the tag.
module pelican_host_ctrl
  import pelican_pkg::*;
#(
  parameter int TIMEOUT = 2047
) (
  input  logic clk,
  input  logic rst,
  pelican_host_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  msg_idx_q, msg_idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              m_pend_q;
  logic              err_q, err_d;
  blk_t              tag_q, tag_d;
  logic              tag_valid_q;
  logic              tag_match_q, tag_match_d;
  blk_t              exp_q, exp_d;

  logic              load_iv;
  blk_t              iv_blk, key_blk, msg_blk;

  pelican_blk_buf u_buf (
    .clk       (clk),
    .wr_en_i   (bus.wr_en && (state_q == IDLE)),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .msg_idx_i (msg_idx_q),
    .iv_o      (iv_blk),
    .key_o     (key_blk),
    .msg_o     (msg_blk)
  );

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      msg_idx_q   <= '0;
      tmo_q       <= '0;
      m_pend_q    <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_match_q <= 1'b0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      msg_idx_q   <= msg_idx_d;
      tmo_q       <= tmo_d;
      // The core samples din one cycle after raising load_m.
      m_pend_q    <= (state_q == RUN) && bus.core_load_m;
      err_q       <= err_d;
      tag_q       <= tag_d;
      // Pulses alongside the freshly captured tag and match flag.
      tag_valid_q <= (state_q == CAPT);
      tag_match_q <= tag_match_d;
      exp_q       <= exp_d;
    end
  end

  // Next-state logic for the run sequencer.
  // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    msg_idx_d   = msg_idx_q;
    tmo_d       = '0;
    err_d       = err_q;
    tag_d       = tag_q;
    tag_match_d = tag_match_q;
    exp_d       = exp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d       = bus.exp_tag;
          err_d       = 1'b0;
          tag_match_d = 1'b0;
          msg_idx_d   = '0;
          state_d     = INIT;
        end
      end
      INIT: state_d = RUN;
      RUN: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Advance past a block once the core has sampled it.
        if (m_pend_q && (msg_idx_q <= IDX_LAST)) begin
          msg_idx_d = msg_idx_q + IDX_W'(1);
        end
        if (bus.core_load_m && (msg_idx_q == IDX_OVER)) begin
          err_d = 1'b1;
        end
        // A done arriving on the timeout cycle still counts as success.
        if (bus.core_done) begin
          state_d = CAPT;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CAPT: begin
        tag_d       = bus.core_dout;
        tag_match_d = (bus.core_dout == exp_q);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_iv = (state_q == INIT);

  // The core is held in reset until its IV has been loaded.
  assign bus.core_rst     = (state_q == IDLE) || (state_q == INIT);
  assign bus.core_load_iv = load_iv;
  assign bus.core_din     = load_iv         ? iv_blk  :
                            bus.core_load_k ? key_blk :
                                              msg_blk;

  assign bus.busy      = (state_q != IDLE);
  assign bus.tag       = tag_q;
  assign bus.tag_valid = tag_valid_q;
  assign bus.tag_match = tag_match_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pelican_host_ctrl.sv
// Directed bench for pelican_host_ctrl with a behavioural stub MAC core.
module tb_pelican_host_ctrl;
  import pelican_pkg::*;

  localparam int M_NORMAL  = 0;
  localparam int M_NODONE  = 1;
  localparam int M_OVERREQ = 2;
  localparam int M_ABORT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pelican_host_ctrl_if bus ();

  pelican_host_ctrl #(.TIMEOUT(2047)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;

  blk_t iv_m, key_m;
  blk_t msg_m [MSG_NUM+1];

  int   tv_cnt, run_cyc, iv_cnt;
  logic hung;
  blk_t tag_seen;
  logic match_seen;

  task automatic check(input string name, input blk_t got, input blk_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Toy MAC used by the stub core: rotate-left then xor.
  function automatic blk_t mix(input blk_t s, input blk_t d);
    return {s[W-2:0], s[W-1]} ^ d;
  endfunction

  function automatic blk_t model_tag();
    blk_t s;
    s = iv_m;
    s = mix(s, key_m);
    for (int k = 0; k <= MSG_NUM; k++) s = mix(s, msg_m[k]);
    s = mix(s, key_m);
    return s;
  endfunction

  task automatic wr(input logic [ADDR_W-1:0] a, input blk_t d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Stub MAC core: captures IV in reset, loads key, requests the message
  // blocks, reloads key, then reports the tag.
  task automatic core_stub(input int mode);
    blk_t s;
    int   guard;
    int   nblk;
    s = '0; guard = 0; iv_cnt = 0;
    bus.core_load_k = 1'b0; bus.core_load_m = 1'b0; bus.core_done = 1'b0;
    do begin
      @(negedge clk); #1; guard++;
      if (bus.core_load_iv) begin s = bus.core_din; iv_cnt++; end
    end while (bus.core_rst && guard < 50);
    if (mode != M_NODONE) begin
      bus.core_load_k = 1'b1; #1;
      check("din_key_first", bus.core_din, key_m);
      s = mix(s, bus.core_din);
      if (mode != M_ABORT) begin
        nblk = (mode == M_OVERREQ) ? MSG_NUM + 2 : MSG_NUM + 1;
        for (int k = 0; k < nblk; k++) begin
          @(negedge clk);
          bus.core_load_k = 1'b0;
          if (k == MSG_NUM + 1) check("err_before_extra", bus.err, 1'b0);
          bus.core_load_m = 1'b1;
          @(negedge clk);
          bus.core_load_m = 1'b0; #1;
          check($sformatf("din_msg%0d", k), bus.core_din, msg_m[(k > MSG_NUM) ? MSG_NUM : k]);
          if (k <= MSG_NUM) s = mix(s, bus.core_din);
        end
        if (mode == M_OVERREQ) check("err_after_extra", bus.err, 1'b1);
        @(negedge clk);
        bus.core_load_k = 1'b1; #1;
        check("din_key_final", bus.core_din, key_m);
        s = mix(s, bus.core_din);
        @(negedge clk);
        bus.core_load_k = 1'b0;
        bus.core_done   = 1'b1;
        bus.core_dout   = s;
        @(negedge clk);
        bus.core_done   = 1'b0;
      end else begin
        @(negedge clk);
        bus.core_load_k = 1'b0;
      end
    end
    guard = 0;
    while (!bus.core_rst && guard < 3000) begin
      @(negedge clk); #1; guard++;
    end
    bus.core_load_k = 1'b0; bus.core_load_m = 1'b0; bus.core_done = 1'b0;
  endtask

  // Host-side observer; optionally writes during RUN or resets mid-run.
  task automatic host_mon(input int mode, input bit wr_in_run);
    bit seen_busy = 1'b0;
    bit wrote     = 1'b0;
    bit did_rst   = 1'b0;
    int guard     = 0;
    tv_cnt = 0; run_cyc = 0; hung = 1'b1; tag_seen = '0; match_seen = 1'b0;
    while (guard < 3000) begin
      @(negedge clk); #1; guard++;
      if (bus.busy) seen_busy = 1'b1;
      if (!bus.core_rst) run_cyc++;
      if (bus.tag_valid) begin
        tv_cnt++; tag_seen = bus.tag; match_seen = bus.tag_match;
      end
      if (seen_busy && !bus.busy) begin hung = 1'b0; break; end
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (wr_in_run && run_cyc == 3 && !wrote) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'(ADDR_MSG0 + 1);
        bus.wr_data = {W/8{8'hEE}};
        wrote       = 1'b1;
      end
      if (mode == M_ABORT && run_cyc == 4 && !did_rst) begin
        rst = 1'b1; did_rst = 1'b1;
      end
    end
    bus.start = 1'b0; bus.wr_en = 1'b0; rst = 1'b0;
  endtask

  task automatic do_run(input int mode, input blk_t exp, input bit wr_start,
                        input blk_t new_iv, input bit wr_in_run);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.exp_tag = exp;
    if (wr_start) begin
      bus.wr_en = 1'b1; bus.wr_addr = ADDR_IV; bus.wr_data = new_iv;
    end
    fork
      core_stub(mode);
      host_mon(mode, wr_in_run);
    join
  endtask

  task automatic post_run(input string nm, input int e_tv, input blk_t e_tag,
                          input logic e_match, input logic e_err);
    check({nm, "_ended"}, hung, 1'b0);
    check({nm, "_tv_cnt"}, tv_cnt, e_tv);
    if (e_tv > 0) begin
      check({nm, "_tag"}, tag_seen, e_tag);
      check({nm, "_match"}, match_seen, e_match);
    end
    check({nm, "_err"}, bus.err, e_err);
    check({nm, "_busy"}, bus.busy, 1'b0);
    check({nm, "_core_rst"}, bus.core_rst, 1'b1);
    check({nm, "_iv_loads"}, iv_cnt, 1);
    @(negedge clk); #1;
    check({nm, "_tv_single"}, bus.tag_valid, 1'b0);
  endtask

  initial begin
    blk_t exp;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.exp_tag = '0;
    bus.core_load_k = 1'b0; bus.core_load_m = 1'b0;
    bus.core_dout = '0; bus.core_done = 1'b0;

    // Reset values.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_tag", bus.tag, '0);
    check("rst_tag_valid", bus.tag_valid, 1'b0);
    check("rst_tag_match", bus.tag_match, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_core_rst", bus.core_rst, 1'b1);
    check("rst_core_load_iv", bus.core_load_iv, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Buffer contents: IV=0, key=00..0F, message k = bytes 16k..16k+15.
    iv_m  = '0;
    key_m = 128'h000102030405060708090a0b0c0d0e0f;
    for (int k = 0; k <= MSG_NUM; k++)
      for (int i = 0; i < 16; i++) msg_m[k][127-8*i -: 8] = 8'(16*k + i);
    wr(ADDR_IV, iv_m);
    wr(ADDR_KEY, key_m);
    for (int k = 0; k <= MSG_NUM; k++) wr(3'(ADDR_MSG0 + k), msg_m[k]);
    wr(3'd7, {W/8{8'h5A}});  // out of range, must be dropped

    // Golden run.
    exp = model_tag();
    do_run(M_NORMAL, exp, 1'b0, '0, 1'b0);
    post_run("golden", 1, exp, 1'b1, 1'b0);

    // Expected tag off by one bit.
    do_run(M_NORMAL, exp ^ blk_t'(1), 1'b0, '0, 1'b0);
    post_run("mismatch", 1, exp, 1'b0, 1'b0);

    // Core never finishes: timeout after 2048 RUN cycles.
    do_run(M_NODONE, exp, 1'b0, '0, 1'b0);
    check("timeout_run_cycles", run_cyc, 2048);
    check("timeout_match_cleared", bus.tag_match, 1'b0);
    post_run("timeout", 0, '0, 1'b0, 1'b1);

    // Fifth message request plus a write during RUN.
    do_run(M_OVERREQ, exp, 1'b0, '0, 1'b1);
    post_run("overreq", 1, exp, 1'b1, 1'b1);

    // Buffer untouched by the RUN write; err cleared by the new start.
    do_run(M_NORMAL, exp, 1'b0, '0, 1'b0);
    post_run("rerun", 1, exp, 1'b1, 1'b0);

    // Reset mid-RUN: no tag_valid, everything back to reset values.
    do_run(M_ABORT, exp, 1'b0, '0, 1'b0);
    check("abort_tag_zero", bus.tag, '0);
    check("abort_match", bus.tag_match, 1'b0);
    post_run("abort", 0, '0, 1'b0, 1'b0);

    // Fresh run with a new IV written in the same cycle as start.
    iv_m = 128'hdeadbeef_01234567_89abcdef_feedface;
    exp  = model_tag();
    do_run(M_NORMAL, exp, 1'b1, iv_m, 1'b0);
    post_run("new_iv", 1, exp, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
